// File: rtl/pamiec_dma_pkg.sv
// Shared types and constants for the pamiec DMA copy engine.
package pamiec_pkg;

  localparam int DEF_ADDR_WIDTH_MEM    = 8;
  localparam int DEF_DATA_WIDTH_MEM    = 8;
  localparam int DEF_DATA_WIDTH_STRONY = 4;
  localparam int DEF_LEN_WIDTH         = 12;

  // Logical offset of the memory's page register.
  localparam int PAGE_REG_ADDR = 2**DEF_ADDR_WIDTH_MEM - 1;

  // Linear address: {page, offset}.
  typedef logic [DEF_DATA_WIDTH_STRONY+DEF_ADDR_WIDTH_MEM-1:0] lin_addr_t;

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    SRC_PG,
    RD,
    DST_PG,
    WR,
    RESTORE,
    DONE
  } dma_state_t;

endpackage

// File: rtl/pamiec_dma_if.sv
// Request/status and paged-memory bus of the pamiec DMA engine.
// slave: the DMA engine; master: the CPU/memory side.
interface pamiec_dma_if #(
  parameter int ADDR_WIDTH_MEM    = 8,
  parameter int DATA_WIDTH_MEM    = 8,
  parameter int DATA_WIDTH_STRONY = 4,
  parameter int LEN_WIDTH         = 12
);
  logic                                      start;
  logic [DATA_WIDTH_STRONY+ADDR_WIDTH_MEM-1:0] src_addr;
  logic [DATA_WIDTH_STRONY+ADDR_WIDTH_MEM-1:0] dst_addr;
  logic [LEN_WIDTH-1:0]                      len;
  logic                                      busy;
  logic                                      done;
  logic                                      err;
  logic                                      mem_wr;
  logic [ADDR_WIDTH_MEM-1:0]                 mem_adres;
  logic [DATA_WIDTH_MEM-1:0]                 mem_dane;
  logic [DATA_WIDTH_MEM-1:0]                 mem_out;

  modport slave (
    input  start, src_addr, dst_addr, len, mem_out,
    output busy, done, err, mem_wr, mem_adres, mem_dane
  );

  modport master (
    output start, src_addr, dst_addr, len, mem_out,
    input  busy, done, err, mem_wr, mem_adres, mem_dane
  );
endinterface

// File: rtl/pamiec_dma_addr_inc.sv
// Advance a {page, offset} address by one data word; offset 2^AW-1 is the
// page register and is skipped, page number wraps.
module pamiec_addr_inc
  import pamiec_pkg::*;
#(
  parameter int ADDR_WIDTH_MEM    = DEF_ADDR_WIDTH_MEM,
  parameter int DATA_WIDTH_STRONY = DEF_DATA_WIDTH_STRONY
) (
  input  logic [DATA_WIDTH_STRONY+ADDR_WIDTH_MEM-1:0] addr,
  output logic [DATA_WIDTH_STRONY+ADDR_WIDTH_MEM-1:0] addr_next
);
  localparam int AW = ADDR_WIDTH_MEM;
  localparam int PW = DATA_WIDTH_STRONY;
  localparam logic [AW-1:0] LAST_DATA_OFS = AW'(2**AW - 2);

  logic [AW-1:0] ofs;
  logic [PW-1:0] pg;

  assign ofs = addr[AW-1:0];
  assign pg  = addr[AW+PW-1:AW];

  // Last data offset rolls into offset 0 of the next page.
  always_comb begin
    if (ofs == LAST_DATA_OFS) addr_next = {pg + PW'(1), AW'(0)};
    else                      addr_next = {pg, ofs + AW'(1)};
  end
endmodule

// File: rtl/pamiec_dma.sv
// pamiec DMA: memory-to-memory copy engine in front of the paged data memory.
// Programs the page register itself and restores the caller's page at the end.
// Optional macro PAMIEC_DMA_PAGE_CACHE_EN: skip page writes whose page already
// matches the tracked current page.
module pamiec_dma
  import pamiec_pkg::*;
#(
  parameter int ADDR_WIDTH_MEM    = DEF_ADDR_WIDTH_MEM,
  parameter int DATA_WIDTH_MEM    = DEF_DATA_WIDTH_MEM,
  parameter int DATA_WIDTH_STRONY = DEF_DATA_WIDTH_STRONY,
  parameter int LEN_WIDTH         = DEF_LEN_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  pamiec_dma_if.slave  bus
);
  localparam int AW = ADDR_WIDTH_MEM;
  localparam int PW = DATA_WIDTH_STRONY;
  localparam int LW = PW + AW;
  localparam logic [AW-1:0] PAGE_REG = AW'(2**AW - 1);

  dma_state_t state, nxt;

  logic [LW-1:0]             src_q, dst_q, src_d, dst_d, src_inc, dst_inc;
  logic [LEN_WIDTH-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]             saved_q, saved_d;
  logic [DATA_WIDTH_MEM-1:0] data_q, data_d;
  logic                      err_q, err_d;
  logic                      req_bad;
`ifdef PAMIEC_DMA_PAGE_CACHE_EN
  logic [PW-1:0]             cur_q, cur_d;
`endif

  pamiec_addr_inc #(.ADDR_WIDTH_MEM(AW), .DATA_WIDTH_STRONY(PW)) u_src_inc (
    .addr      (src_q),
    .addr_next (src_inc)
  );

  pamiec_addr_inc #(.ADDR_WIDTH_MEM(AW), .DATA_WIDTH_STRONY(PW)) u_dst_inc (
    .addr      (dst_q),
    .addr_next (dst_inc)
  );

  assign req_bad = (bus.src_addr[AW-1:0] == PAGE_REG) || (bus.dst_addr[AW-1:0] == PAGE_REG);

  // Next state and next working-register values.
  always_comb begin
    nxt     = state;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    saved_d = saved_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef PAMIEC_DMA_PAGE_CACHE_EN
    cur_d   = cur_q;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          err_d = req_bad;
          if (req_bad || bus.len == '0) begin
            nxt = DONE;
          end else begin
            src_d = bus.src_addr;
            dst_d = bus.dst_addr;
            cnt_d = bus.len;
            nxt   = SAVE;
          end
        end
      end
      SAVE: begin
        saved_d = bus.mem_out[PW-1:0];
`ifdef PAMIEC_DMA_PAGE_CACHE_EN
        cur_d = bus.mem_out[PW-1:0];
        nxt   = (bus.mem_out[PW-1:0] == src_q[LW-1:AW]) ? RD : SRC_PG;
`else
        nxt = SRC_PG;
`endif
      end
      SRC_PG: begin
`ifdef PAMIEC_DMA_PAGE_CACHE_EN
        cur_d = src_q[LW-1:AW];
`endif
        nxt = RD;
      end
      RD: begin
        data_d = bus.mem_out;
`ifdef PAMIEC_DMA_PAGE_CACHE_EN
        nxt = (cur_q == dst_q[LW-1:AW]) ? WR : DST_PG;
`else
        nxt = DST_PG;
`endif
      end
      DST_PG: begin
`ifdef PAMIEC_DMA_PAGE_CACHE_EN
        cur_d = dst_q[LW-1:AW];
`endif
        nxt = WR;
      end
      WR: begin
        src_d = src_inc;
        dst_d = dst_inc;
        cnt_d = cnt_q - LEN_WIDTH'(1);
`ifdef PAMIEC_DMA_PAGE_CACHE_EN
        if (cnt_q == LEN_WIDTH'(1)) nxt = (cur_q == saved_q) ? DONE : RESTORE;
        else                        nxt = (cur_q == src_inc[LW-1:AW]) ? RD : SRC_PG;
`else
        nxt = (cnt_q == LEN_WIDTH'(1)) ? RESTORE : SRC_PG;
`endif
      end
      RESTORE: nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the state being entered, so they are valid
  // for the whole cycle the FSM spends in that state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      cnt_q         <= '0;
      saved_q       <= '0;
      data_q        <= '0;
      err_q         <= 1'b0;
`ifdef PAMIEC_DMA_PAGE_CACHE_EN
      cur_q         <= '0;
`endif
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_adres <= '0;
      bus.mem_dane  <= '0;
    end else begin
      state   <= nxt;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      saved_q <= saved_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef PAMIEC_DMA_PAGE_CACHE_EN
      cur_q   <= cur_d;
`endif
      bus.busy      <= (nxt != IDLE) && (nxt != DONE);
      bus.done      <= (nxt == DONE);
      bus.err       <= (nxt == DONE) && err_d;
      bus.mem_wr    <= 1'b0;
      bus.mem_adres <= '0;
      bus.mem_dane  <= '0;
      case (nxt)
        SAVE: bus.mem_adres <= PAGE_REG;
        SRC_PG: begin
          bus.mem_wr    <= 1'b1;
          bus.mem_adres <= PAGE_REG;
          bus.mem_dane  <= DATA_WIDTH_MEM'(src_d[LW-1:AW]);
        end
        RD: bus.mem_adres <= src_d[AW-1:0];
        DST_PG: begin
          bus.mem_wr    <= 1'b1;
          bus.mem_adres <= PAGE_REG;
          bus.mem_dane  <= DATA_WIDTH_MEM'(dst_d[LW-1:AW]);
        end
        WR: begin
          bus.mem_wr    <= 1'b1;
          bus.mem_adres <= dst_d[AW-1:0];
          bus.mem_dane  <= data_d;
        end
        RESTORE: begin
          bus.mem_wr    <= 1'b1;
          bus.mem_adres <= PAGE_REG;
          bus.mem_dane  <= DATA_WIDTH_MEM'(saved_d);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pamiec_dma.sv
// Self-checking bench for pamiec_dma with a paged memory model and a
// word-sequence reference model of the copy.
module tb_pamiec_dma;
  import pamiec_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pamiec_dma_if #(.ADDR_WIDTH_MEM(8), .DATA_WIDTH_MEM(8), .DATA_WIDTH_STRONY(4), .LEN_WIDTH(12)) bus ();

  pamiec_dma #(.ADDR_WIDTH_MEM(8), .DATA_WIDTH_MEM(8), .DATA_WIDTH_STRONY(4), .LEN_WIDTH(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Paged memory: 16 pages x 256 words, offset 255 is the page register.
  logic [7:0] mem     [0:4095];
  logic [7:0] exp_mem [0:4095];
  logic [3:0] pg_reg;
  int data_wr, page_wr, dones;
  int total = 0;
  int bad   = 0;

  assign bus.mem_out = (bus.mem_adres == 8'hFF) ? {4'h0, pg_reg} : mem[{pg_reg, bus.mem_adres}];

  always @(posedge clk) begin
    if (bus.mem_wr) begin
      if (bus.mem_adres == 8'hFF) begin
        pg_reg <= bus.mem_dane[3:0];
        page_wr++;
      end else begin
        mem[{pg_reg, bus.mem_adres}] <= bus.mem_dane;
        data_wr++;
      end
    end
  end

  always @(negedge clk) if (bus.done) dones++;

  task automatic chk(input int id, input string what, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL case%0d %s actual=%0d required=%0d", id, what, act, req);
    end
  endtask

  // Next data address: offset 254 rolls to offset 0 of the next page (mod 16).
  function automatic lin_addr_t adv(input lin_addr_t a);
    int off = int'(a) % 256;
    int pg  = int'(a) / 256;
    if (off == 254) return lin_addr_t'(((pg + 1) % 16) * 256);
    return lin_addr_t'(int'(a) + 1);
  endfunction

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  task automatic run_xfer(input int id, input lin_addr_t s, input lin_addr_t d, input int n,
                          input int ipg, input bit e_err, input int e_cyc, input int restart_at);
    int cyc;
    int busy_bad;
    bit got;
    bit err_seen;
    lin_addr_t a;
    lin_addr_t b;
    @(negedge clk);
    pg_reg = 4'(ipg);
    exp_mem = mem;
    if (!e_err) begin
      a = s;
      b = d;
      for (int i = 0; i < n; i++) begin
        exp_mem[b] = exp_mem[a];
        a = adv(a);
        b = adv(b);
      end
    end
    data_wr = 0;
    page_wr = 0;
    dones   = 0;
    bus.src_addr = s;
    bus.dst_addr = d;
    bus.len      = 12'(n);
    bus.start    = 1'b1;
    @(posedge clk);
    cyc = 0;
    got = 0;
    busy_bad = 0;
    err_seen = 0;
    while (!got && cyc < e_cyc + 50) begin
      @(negedge clk);
      cyc++;
      if (restart_at != 0 && cyc == restart_at) begin
        bus.start    = 1'b1;
        bus.src_addr = 12'h700;
        bus.dst_addr = 12'h800;
        bus.len      = 12'd2;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        got = 1;
        err_seen = bus.err;
      end
      if (bus.busy !== (cyc < e_cyc)) busy_bad++;
    end
    chk(id, "done_seen", got, 1);
    chk(id, "done_cycle", cyc, e_cyc);
    chk(id, "err", err_seen, e_err);
    chk(id, "busy_profile", busy_bad, 0);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    chk(id, "done_pulses", dones, 1);
    chk(id, "mem_image_diffs", mem_diffs(), 0);
    chk(id, "page_after", pg_reg, ipg);
    chk(id, "data_writes", data_wr, e_err ? 0 : n);
    chk(id, "page_writes", page_wr, (e_err || n == 0) ? 0 : 2 * n + 1);
  endtask

  typedef struct {
    lin_addr_t src;
    lin_addr_t dst;
    int        len;
    int        init_pg;
    bit        exp_err;
    int        exp_cyc;
    int        restart_at;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{12'h010, 12'h220,  3, 1, 1'b0, 15, 0};  // copy within a page
    tbl[1] = '{12'h0FD, 12'h330,  3, 5, 1'b0, 15, 0};  // source crosses page
    tbl[2] = '{12'hFFE, 12'h0F0,  2, 2, 1'b0, 11, 0};  // page 15 wraps to 0
    tbl[3] = '{12'h123, 12'h1F0, 20, 9, 1'b0, 83, 0};  // dst crosses page
    tbl[4] = '{12'h010, 12'h020,  0, 4, 1'b0,  1, 0};  // len 0
    tbl[5] = '{12'h2FF, 12'h020,  3, 6, 1'b1,  1, 0};  // src offset 255
    tbl[6] = '{12'h010, 12'h4FF,  5, 7, 1'b1,  1, 0};  // dst offset 255
    tbl[7] = '{12'h500, 12'h502,  4, 0, 1'b0, 19, 0};  // overlapping, ascending
    tbl[8] = '{12'h040, 12'h060,  3, 8, 1'b0, 15, 6};  // second start ignored
    tbl[9] = '{12'h7AA, 12'h7AB,  1, 0, 1'b0,  7, 0};  // single word

    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h010] = 8'hA1;
    mem[12'h011] = 8'hA2;
    mem[12'h012] = 8'hA3;
    pg_reg    = 4'h0;
    bus.start    = 1'b0;
    bus.src_addr = '0;
    bus.dst_addr = '0;
    bus.len      = '0;

    repeat (3) @(negedge clk);
    chk(0, "rst_busy", bus.busy, 0);
    chk(0, "rst_done", bus.done, 0);
    chk(0, "rst_err", bus.err, 0);
    chk(0, "rst_mem_wr", bus.mem_wr, 0);
    chk(0, "rst_mem_adres", bus.mem_adres, 0);
    chk(0, "rst_mem_dane", bus.mem_dane, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++)
      run_xfer(i + 1, tbl[i].src, tbl[i].dst, tbl[i].len, tbl[i].init_pg,
               tbl[i].exp_err, tbl[i].exp_cyc, tbl[i].restart_at);

    // Explicit contents of the in-page copy destination.
    chk(1, "dst_220", mem[12'h220], 8'hA1);
    chk(1, "dst_221", mem[12'h221], 8'hA2);
    chk(1, "dst_222", mem[12'h222], 8'hA3);

    // Reset during the WR state of word 2 of 5.
    @(negedge clk);
    pg_reg = 4'h3;
    exp_mem = mem;
    exp_mem[12'h640] = mem[12'h310];
    dones   = 0;
    data_wr = 0;
    bus.src_addr = 12'h310;
    bus.dst_addr = 12'h640;
    bus.len      = 12'd5;
    bus.start    = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk(30, "wr_before_reset", bus.mem_wr, 1);
    chk(30, "adres_before_reset", bus.mem_adres, 8'h41);
    rst = 1'b0;
    #1;
    chk(30, "busy_in_reset", bus.busy, 0);
    chk(30, "mem_wr_in_reset", bus.mem_wr, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk(30, "no_done_after_abort", dones, 0);
    chk(30, "words_before_abort", data_wr, 1);
    chk(30, "mem_after_abort", mem_diffs(), 0);
    run_xfer(31, 12'h310, 12'h640, 5, 3, 1'b0, 23, 0);

    // Randomized transfers checked against the reference model.
    for (int k = 0; k < 25; k++) begin
      lin_addr_t s;
      lin_addr_t d;
      int n;
      s = {4'($urandom), 8'($urandom_range(0, 254))};
      d = {4'($urandom), 8'($urandom_range(0, 254))};
      n = int'($urandom_range(1, 12));
      run_xfer(100 + k, s, d, n, int'($urandom_range(0, 15)), 1'b0, 4 * n + 3, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
